// File: rtl/weave_pkg.sv
// Shared defaults and helpers for the round-robin shared-adder scheduler.
// Imported by the arbiter and the top level.
package weave_pkg;

   localparam int W_DEFAULT    = 8;
   localparam int NREQ_DEFAULT = 2;

   // An id field is never narrower than one bit, even for tiny requester counts.
   function automatic int id_width(input int n);
      if (n <= 2) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/weave_adder_sched_arb.sv
// Combinational rotate-priority encoder: the search starts one past the last winner.
// The one-hot grant is suppressed when en is low; gnt_idx still names the candidate.
module rr_arbiter
   import weave_pkg::*;
#(
   parameter int N   = NREQ_DEFAULT,
   parameter int IDW = id_width(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] last,
   input  logic           en,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_idx
);

   int   cand;
   logic found;

   // Walk the requesters in rotated order and keep the first valid one.
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      cand    = 0;
      for (int k = 1; k <= N; k++) begin
         cand = (int'(last) + k) % N;
         if (!found && req[cand]) begin
            found   = 1'b1;
            gnt_idx = IDW'(cand);
         end else begin
            found   = found;
         end
      end
      if (en && found) begin
         gnt = {{(N-1){1'b0}}, 1'b1} << gnt_idx;
      end else begin
         gnt = '0;
      end
   end

endmodule

// File: rtl/weave_adder_sched.sv
// Shares one W-bit adder among NREQ requesters with round-robin grants and a
// single-entry result register on a valid/ready output channel.
module weave_adder_sched
   import weave_pkg::*;
#(
   parameter int NREQ = NREQ_DEFAULT,
   parameter int W    = W_DEFAULT,
   parameter int IDW  = id_width(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [W-1:0]      res_data,
   output logic              res_carry,
   output logic [IDW-1:0]    res_id,
   output logic              busy
);

   logic            res_valid_q, res_valid_d;
   logic [W-1:0]    res_data_q,  res_data_d;
   logic            res_carry_q, res_carry_d;
   logic [IDW-1:0]  res_id_q,    res_id_d;
   logic [IDW-1:0]  last_grant_q, last_grant_d;

   logic            can_issue;
   logic            arb_en;
   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  gnt_idx;
   logic            transfer;
   logic [W-1:0]    op_a;
   logic [W-1:0]    op_b;
   logic [W:0]      sum;

   // Grants stay off while reset is held so nothing appears to transfer.
   assign can_issue = !res_valid_q || res_ready;
   assign arb_en    = can_issue && !rst;

   rr_arbiter #(
      .N   (NREQ),
      .IDW (IDW)
   ) u_arb (
      .req     (req_valid),
      .last    (last_grant_q),
      .en      (arb_en),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign transfer  = |gnt;
   assign req_ready = gnt;
   assign op_a      = req_a[int'(gnt_idx)*W +: W];
   assign op_b      = req_b[int'(gnt_idx)*W +: W];
   assign sum       = {1'b0, op_a} + {1'b0, op_b};

   // Next-state: load on transfer, drop valid on a pure drain, otherwise hold.
   always_comb begin
      res_valid_d  = res_valid_q;
      res_data_d   = res_data_q;
      res_carry_d  = res_carry_q;
      res_id_d     = res_id_q;
      last_grant_d = last_grant_q;
      if (transfer) begin
         res_valid_d  = 1'b1;
         res_data_d   = sum[W-1:0];
         res_carry_d  = sum[W];
         res_id_d     = gnt_idx;
         last_grant_d = gnt_idx;
      end else if (res_valid_q && res_ready) begin
         res_valid_d  = 1'b0;
      end else begin
         res_valid_d  = res_valid_q;
      end
   end

   // Result register and rotation pointer; reset restarts priority at requester 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid_q  <= 1'b0;
         res_data_q   <= '0;
         res_carry_q  <= 1'b0;
         res_id_q     <= '0;
         last_grant_q <= IDW'(NREQ - 1);
      end else begin
         res_valid_q  <= res_valid_d;
         res_data_q   <= res_data_d;
         res_carry_q  <= res_carry_d;
         res_id_q     <= res_id_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_carry = res_carry_q;
   assign res_id    = res_id_q;
   assign busy      = res_valid_q || (|req_valid);

endmodule

// File: tb/tb_weave_adder_sched.sv
// Scoreboard bench for weave_adder_sched: a reference arbiter/result model pushes
// expected results on each modelled grant and compares them while the DUT holds them.
module tb_weave_adder_sched;

   localparam int NREQ = 2;
   localparam int W    = 8;
   localparam int IDW  = 1;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic           carry;
      logic [W-1:0]   data;
   } res_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic              res_valid;
   logic              res_ready;
   logic [W-1:0]      res_data;
   logic              res_carry;
   logic [IDW-1:0]    res_id;
   logic              busy;

   weave_adder_sched #(.NREQ(NREQ), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_carry (res_carry),
      .res_id    (res_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [2*W-1:0]  stim_q [NREQ][$];
   res_t            exp_q[$];
   res_t            log_q[$];
   int              log_cyc[$];
   logic            m_valid;
   logic [IDW-1:0]  m_last;
   logic [NREQ-1:0] m_gnt;
   logic [NREQ-1:0] snap_ready;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic present();
      for (int i = 0; i < NREQ; i++) begin
         if (stim_q[i].size() > 0) begin
            req_valid[i]     = 1'b1;
            req_a[i*W +: W]  = stim_q[i][0][2*W-1:W];
            req_b[i*W +: W]  = stim_q[i][0][W-1:0];
         end else begin
            req_valid[i]     = 1'b0;
            req_a[i*W +: W]  = '0;
            req_b[i*W +: W]  = '0;
         end
      end
   endtask

   task automatic monitor();
      logic [NREQ-1:0] exp_gnt;
      logic            found;
      int              win;
      int              idx;
      logic [W:0]      s;
      res_t            r;
      @(negedge clk);
      cyc++;
      snap_ready = req_ready;
      if (rst) begin
         m_valid = 1'b0;
         m_last  = IDW'(NREQ - 1);
         m_gnt   = '0;
         exp_q.delete();
         check_val("rst_req_ready", 32'(req_ready), 32'd0);
      end else begin
         check_val("res_valid", 32'(res_valid), 32'(m_valid));
         check_val("busy", 32'(busy), 32'(m_valid | (|req_valid)));
         if (m_valid) begin
            check_val("sb_depth", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) begin
               check_val("res_data", 32'(res_data), 32'(exp_q[0].data));
               check_val("res_carry", 32'(res_carry), 32'(exp_q[0].carry));
               check_val("res_id", 32'(res_id), 32'(exp_q[0].id));
            end
         end
         exp_gnt = '0;
         found   = 1'b0;
         win     = 0;
         if (!m_valid || res_ready) begin
            for (int k = 1; k <= NREQ; k++) begin
               idx = (int'(m_last) + k) % NREQ;
               if (!found && req_valid[idx]) begin
                  found = 1'b1;
                  win   = idx;
               end
            end
         end
         if (found) exp_gnt[win] = 1'b1;
         check_val("req_ready", 32'(req_ready), 32'(exp_gnt));
         if (m_valid && res_ready) begin
            log_q.push_back('{id: res_id, carry: res_carry, data: res_data});
            log_cyc.push_back(cyc);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end
         if (found) begin
            s = {1'b0, stim_q[win][0][2*W-1:W]} + {1'b0, stim_q[win][0][W-1:0]};
            r = '{id: IDW'(win), carry: s[W], data: s[W-1:0]};
            exp_q.push_back(r);
            m_last  = IDW'(win);
            m_valid = 1'b1;
         end else if (m_valid && res_ready) begin
            m_valid = 1'b0;
         end
         m_gnt = exp_gnt;
      end
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) begin
         monitor();
         @(posedge clk);
         #1;
         for (int i = 0; i < NREQ; i++) begin
            if (m_gnt[i] && stim_q[i].size() > 0) void'(stim_q[i].pop_front());
         end
         m_gnt = '0;
         present();
      end
   endtask

   initial begin
      logic [IDW-1:0] fair_ids [6];
      int pending;
      rst       = 1'b1;
      res_ready = 1'b1;
      m_valid   = 1'b0;
      m_last    = IDW'(NREQ - 1);
      m_gnt     = '0;
      present();
      @(posedge clk);
      #1;
      check_val("reset_res_valid", 32'(res_valid), 32'd0);
      check_val("reset_res_data", 32'(res_data), 32'd0);
      check_val("reset_res_carry", 32'(res_carry), 32'd0);
      check_val("reset_res_id", 32'(res_id), 32'd0);
      check_val("reset_busy", 32'(busy), 32'd0);
      rst = 1'b0;

      stim_q[0].push_back({8'h12, 8'h34});
      present();
      run(3);
      check_val("single_count", 32'(log_q.size()), 32'd1);
      if (log_q.size() > 0) begin
         check_val("single_data", 32'(log_q[0].data), 32'h46);
         check_val("single_carry", 32'(log_q[0].carry), 32'd0);
         check_val("single_id", 32'(log_q[0].id), 32'd0);
      end
      log_q.delete();
      log_cyc.delete();

      stim_q[1].push_back({8'hFF, 8'h01});
      present();
      run(3);
      check_val("carry_count", 32'(log_q.size()), 32'd1);
      if (log_q.size() > 0) begin
         check_val("carry_data", 32'(log_q[0].data), 32'h00);
         check_val("carry_carry", 32'(log_q[0].carry), 32'd1);
      end
      log_q.delete();
      log_cyc.delete();

      // Fairness: last grant was requester 1, so rotation resumes at 0.
      for (int k = 0; k < 3; k++) begin
         stim_q[0].push_back({8'(8'h10 + k), 8'(8'h20 + k)});
         stim_q[1].push_back({8'(8'hF0 + k), 8'(8'h30 + k)});
      end
      present();
      run(10);
      fair_ids = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      check_val("fair_count", 32'(log_q.size()), 32'd6);
      for (int k = 0; k < 6 && k < log_q.size(); k++) begin
         check_val("fair_id", 32'(log_q[k].id), 32'(fair_ids[k]));
         if (k > 0) check_val("fair_no_bubble", 32'(log_cyc[k] - log_cyc[k-1]), 32'd1);
      end
      log_q.delete();
      log_cyc.delete();

      // Backpressure: hold a result for three cycles, then drain and regrant together.
      res_ready = 1'b0;
      stim_q[0].push_back({8'h55, 8'h66});
      stim_q[1].push_back({8'h80, 8'h80});
      present();
      run(1);
      run(3);
      check_val("bp_hold_ready", 32'(snap_ready), 32'd0);
      check_val("bp_hold_valid", 32'(res_valid), 32'd1);
      res_ready = 1'b1;
      run(1);
      check_val("bp_drain_grant", 32'(snap_ready), 32'b10);
      run(2);
      check_val("drain_valid", 32'(res_valid), 32'd0);
      check_val("drain_busy", 32'(busy), 32'd0);

      // Reset in the middle of a burst.
      for (int k = 0; k < 4; k++) begin
         stim_q[0].push_back({8'(8'h01 + k), 8'h02});
         stim_q[1].push_back({8'(8'h40 + k), 8'h03});
      end
      present();
      run(3);
      rst = 1'b1;
      #1;
      check_val("rst_async_valid", 32'(res_valid), 32'd0);
      check_val("rst_async_ready", 32'(req_ready), 32'd0);
      run(2);
      rst = 1'b0;
      run(1);
      check_val("rst_first_grant", 32'(snap_ready), 32'b01);

      // Random traffic with random backpressure.
      for (int c = 0; c < 200; c++) begin
         res_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NREQ; i++) begin
            if (stim_q[i].size() < 2 && $urandom_range(0, 1) == 1)
               stim_q[i].push_back(16'($urandom_range(0, 65535)));
         end
         present();
         run(1);
      end

      res_ready = 1'b1;
      pending   = 1;
      for (int c = 0; c < 60 && pending != 0; c++) begin
         run(1);
         pending = stim_q[0].size() + stim_q[1].size() + exp_q.size();
      end
      check_val("final_drain_timeout", 32'(pending), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
